// File: rtl/max2831_spi_writer.sv
// Purpose: arbitrates AFC and host register writes and serializes one 18-bit word to the MAX2831 3-wire SPI.
// Latency: request accepted at edge T, grant/SHIFT from T+1, ready again at T+1+37*CLK_DIV.
// Backpressure: level requests held until granted; max2831_ready=0 blocks acceptance. Macro MAX2831_HOST_PORT_EN enables the host port.
module max2831_spi_writer #(
  parameter int CLK_DIV = 2
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        afc_req,
  input  logic [13:0] afc_data,
  input  logic        afc_msb_lsb,
  output logic        afc_grant,
  input  logic        host_req,
  input  logic [17:0] host_word,
  output logic        host_grant,
  output logic        max2831_ready,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_din
);

  typedef enum logic [1:0] {IDLE, SHIFT, GUARD} state_t;

  // Last divider count of a half-period (low phase, high phase, or guard).
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [17:0] sh_q, sh_d;
  logic [4:0]  bit_q, bit_d;
  logic [7:0]  div_q, div_d;
  logic        cs_n_q, cs_n_d;
  logic        sclk_q, sclk_d;
  logic        din_q, din_d;
  logic        afc_g_q, afc_g_d;
  logic        host_g_q, host_g_d;
  logic        rdy_q, rdy_d;

  logic        host_ok;
  logic [17:0] host_w;
  logic [17:0] afc_word;
  logic [17:0] win_word;

`ifdef MAX2831_HOST_PORT_EN
  assign host_ok = host_req;
  assign host_w  = host_word;
`else
  // Host port exists but is never served in this build.
  logic host_unused;
  assign host_ok     = 1'b0;
  assign host_w      = 18'h0;
  assign host_unused = ^{host_req, host_word};
`endif

  // AFC writes target R4 or R3 depending on which half of the AFC value is sent.
  assign afc_word = {afc_data, (afc_msb_lsb ? 4'h4 : 4'h3)};
  // Fixed priority: AFC wins, host stays pending.
  assign win_word = afc_req ? afc_word : host_w;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    bit_d    = bit_q;
    div_d    = div_q;
    cs_n_d   = cs_n_q;
    sclk_d   = sclk_q;
    din_d    = din_q;
    afc_g_d  = 1'b0;
    host_g_d = 1'b0;
    rdy_d    = rdy_q;
    case (state_q)
      IDLE: begin
        if (afc_req || host_ok) begin
          state_d  = SHIFT;
          sh_d     = win_word;
          bit_d    = 5'd17;
          div_d    = 8'd0;
          cs_n_d   = 1'b0;
          sclk_d   = 1'b0;
          din_d    = win_word[17];
          afc_g_d  = afc_req;
          host_g_d = ~afc_req;
          rdy_d    = 1'b0;
        end
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = 8'd0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else if (bit_q == 5'd0) begin
            state_d = GUARD;
            cs_n_d  = 1'b1;
            sclk_d  = 1'b0;
            din_d   = 1'b0;
          end else begin
            // Data moves only at the start of a low phase.
            bit_d  = bit_q - 5'd1;
            sclk_d = 1'b0;
            sh_d   = {sh_q[16:0], 1'b0};
            din_d  = sh_q[16];
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      GUARD: begin
        // CS-high time so the MAX2831 latches the word before the next one.
        if (div_q == DIV_LAST) begin
          state_d = IDLE;
          div_d   = 8'd0;
          bit_d   = 5'd0;
          rdy_d   = 1'b1;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        din_d   = 1'b0;
        rdy_d   = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous reset that aborts any transfer.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q  <= IDLE;
      sh_q     <= 18'h0;
      bit_q    <= 5'd0;
      div_q    <= 8'd0;
      cs_n_q   <= 1'b1;
      sclk_q   <= 1'b0;
      din_q    <= 1'b0;
      afc_g_q  <= 1'b0;
      host_g_q <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      bit_q    <= bit_d;
      div_q    <= div_d;
      cs_n_q   <= cs_n_d;
      sclk_q   <= sclk_d;
      din_q    <= din_d;
      afc_g_q  <= afc_g_d;
      host_g_q <= host_g_d;
      rdy_q    <= rdy_d;
    end
  end

  assign afc_grant     = afc_g_q;
  assign host_grant    = host_g_q;
  assign max2831_ready = rdy_q;
  assign spi_cs_n      = cs_n_q;
  assign spi_sclk      = sclk_q;
  assign spi_din       = din_q;

endmodule

// File: tb/tb_max2831_spi_writer.sv
// Directed bench for max2831_spi_writer with CLK_DIV=2.
// Inputs driven 1 time unit after the rising edge, outputs sampled there too.
// Serial words reconstructed from SCLK rising edges observed at the falling HCLK edge.
module tb_max2831_spi_writer;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        afc_req = 1'b0;
  logic [13:0] afc_data = 14'h0;
  logic        afc_msb_lsb = 1'b0;
  logic        afc_grant;
  logic        host_req = 1'b0;
  logic [17:0] host_word = 18'h0;
  logic        host_grant;
  logic        max2831_ready;
  logic        spi_cs_n;
  logic        spi_sclk;
  logic        spi_din;

  int errors = 0;
  int checks = 0;

  always #5 HCLK = ~HCLK;

  max2831_spi_writer #(.CLK_DIV(2)) dut (
    .HCLK(HCLK),
    .HRESET(HRESET),
    .afc_req(afc_req),
    .afc_data(afc_data),
    .afc_msb_lsb(afc_msb_lsb),
    .afc_grant(afc_grant),
    .host_req(host_req),
    .host_word(host_word),
    .host_grant(host_grant),
    .max2831_ready(max2831_ready),
    .spi_cs_n(spi_cs_n),
    .spi_sclk(spi_sclk),
    .spi_din(spi_din)
  );

  // Serial monitor: shift in DIN on each SCLK rise, flag DIN moving at or during SCLK high.
  logic        prev_sclk = 1'b0;
  logic        prev_din = 1'b0;
  int          rise_cnt = 0;
  int          stab_err = 0;
  logic [17:0] cap = 18'h0;

  always @(negedge HCLK) begin
    if (spi_sclk && !prev_sclk) begin
      rise_cnt = rise_cnt + 1;
      cap = {cap[16:0], spi_din};
      if (spi_din !== prev_din) stab_err = stab_err + 1;
    end else if (spi_sclk && prev_sclk && (spi_din !== prev_din)) begin
      stab_err = stab_err + 1;
    end
    prev_sclk = spi_sclk;
    prev_din  = spi_din;
  end

  // Measurement only: called at the grant sample; runs until ready returns (bounded).
  task automatic run_xfer(input int drop_at, output int k_ready, output int cs_low,
                          output int ag, output int hg);
    k_ready = -1;
    cs_low  = (spi_cs_n === 1'b0) ? 1 : 0;
    ag      = 0;
    hg      = 0;
    for (int k = 1; k <= 300; k++) begin
      @(posedge HCLK); #1;
      if (spi_cs_n === 1'b0) cs_low++;
      if (afc_grant === 1'b1) ag++;
      if (host_grant === 1'b1) hg++;
      if (max2831_ready === 1'b1) begin
        k_ready = k;
        break;
      end
      if (k == drop_at) afc_req = 1'b0;
    end
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    repeat (3) @(posedge HCLK);
    #1;
    checks++; if (spi_cs_n !== 1'b1) begin errors++; $display("FAIL rst_cs_n: got %b want 1", spi_cs_n); end
    checks++; if (spi_sclk !== 1'b0) begin errors++; $display("FAIL rst_sclk: got %b want 0", spi_sclk); end
    checks++; if (spi_din !== 1'b0) begin errors++; $display("FAIL rst_din: got %b want 0", spi_din); end
    checks++; if (afc_grant !== 1'b0) begin errors++; $display("FAIL rst_afc_grant: got %b want 0", afc_grant); end
    checks++; if (host_grant !== 1'b0) begin errors++; $display("FAIL rst_host_grant: got %b want 0", host_grant); end
    checks++; if (max2831_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", max2831_ready); end
    HRESET = 1'b0;
    @(posedge HCLK); #1;
  endtask

  task automatic test_afc_r4();
    int k, csl, ag, hg, r0, s0;
    afc_data = 14'h1000; afc_msb_lsb = 1'b1; afc_req = 1'b1;
    r0 = rise_cnt; s0 = stab_err;
    @(posedge HCLK); #1;
    checks++; if (afc_grant !== 1'b1) begin errors++; $display("FAIL r4_grant: got %b want 1", afc_grant); end
    checks++; if (max2831_ready !== 1'b0) begin errors++; $display("FAIL r4_ready_low: got %b want 0", max2831_ready); end
    checks++; if (host_grant !== 1'b0) begin errors++; $display("FAIL r4_host_grant: got %b want 0", host_grant); end
    afc_req = 1'b0;
    run_xfer(0, k, csl, ag, hg);
    checks++; if (k != 74) begin errors++; $display("FAIL r4_ready_cycle: got %0d want 74", k); end
    checks++; if (csl != 72) begin errors++; $display("FAIL r4_cs_low: got %0d want 72", csl); end
    checks++; if (ag != 0) begin errors++; $display("FAIL r4_grant_pulse: extra grants %0d want 0", ag); end
    checks++; if (rise_cnt - r0 != 18) begin errors++; $display("FAIL r4_rises: got %0d want 18", rise_cnt - r0); end
    checks++; if (cap !== 18'h10004) begin errors++; $display("FAIL r4_word: got %h want 10004", cap); end
    checks++; if (stab_err - s0 != 0) begin errors++; $display("FAIL r4_din_stable: got %0d violations want 0", stab_err - s0); end
    checks++; if (spi_din !== 1'b0 || spi_cs_n !== 1'b1) begin errors++; $display("FAIL r4_end_lines: got din=%b cs_n=%b want 0/1", spi_din, spi_cs_n); end
  endtask

  task automatic test_handshake();
    int k, csl, ag, hg, extra_g, extra_cs;
    afc_data = 14'h0155; afc_msb_lsb = 1'b1; afc_req = 1'b1;
    @(posedge HCLK); #1;
    checks++; if (afc_grant !== 1'b1) begin errors++; $display("FAIL hs_grant: got %b want 1", afc_grant); end
    run_xfer(1, k, csl, ag, hg);
    checks++; if (k != 74) begin errors++; $display("FAIL hs_ready_cycle: got %0d want 74", k); end
    checks++; if (ag != 0) begin errors++; $display("FAIL hs_regrant: got %0d want 0", ag); end
    checks++; if (cap !== 18'h01554) begin errors++; $display("FAIL hs_word: got %h want 01554", cap); end
    extra_g = 0; extra_cs = 0;
    repeat (20) begin
      @(posedge HCLK); #1;
      if (afc_grant === 1'b1) extra_g++;
      if (spi_cs_n === 1'b0) extra_cs++;
    end
    checks++; if (extra_g != 0) begin errors++; $display("FAIL hs_second_grant: got %0d want 0", extra_g); end
    checks++; if (extra_cs != 0) begin errors++; $display("FAIL hs_second_xfer: cs low %0d want 0", extra_cs); end
  endtask

  task automatic test_reset_mid();
    int k, csl, ag, hg, r0, s0;
    afc_data = 14'h1000; afc_msb_lsb = 1'b1; afc_req = 1'b1;
    @(posedge HCLK); #1;
    checks++; if (afc_grant !== 1'b1) begin errors++; $display("FAIL rm_grant: got %b want 1", afc_grant); end
    afc_req = 1'b0;
    repeat (33) @(posedge HCLK);
    #1;
    checks++; if (spi_cs_n !== 1'b0) begin errors++; $display("FAIL rm_in_bit9: cs_n got %b want 0", spi_cs_n); end
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    checks++; if (spi_cs_n !== 1'b1) begin errors++; $display("FAIL rm_cs_n: got %b want 1", spi_cs_n); end
    checks++; if (spi_sclk !== 1'b0) begin errors++; $display("FAIL rm_sclk: got %b want 0", spi_sclk); end
    checks++; if (max2831_ready !== 1'b1) begin errors++; $display("FAIL rm_ready: got %b want 1", max2831_ready); end
    HRESET = 1'b0;
    afc_data = 14'h3078; afc_msb_lsb = 1'b0; afc_req = 1'b1;
    r0 = rise_cnt; s0 = stab_err;
    @(posedge HCLK); #1;
    checks++; if (afc_grant !== 1'b1) begin errors++; $display("FAIL rm_first_accept: got %b want 1", afc_grant); end
    afc_req = 1'b0;
    run_xfer(0, k, csl, ag, hg);
    checks++; if (k != 74) begin errors++; $display("FAIL r3_ready_cycle: got %0d want 74", k); end
    checks++; if (rise_cnt - r0 != 18) begin errors++; $display("FAIL r3_rises: got %0d want 18", rise_cnt - r0); end
    checks++; if (cap !== 18'h30783) begin errors++; $display("FAIL r3_word: got %h want 30783", cap); end
    checks++; if (stab_err - s0 != 0) begin errors++; $display("FAIL r3_din_stable: got %0d violations want 0", stab_err - s0); end
  endtask

`ifdef MAX2831_HOST_PORT_EN
  task automatic test_arbitration();
    int k, csl, ag, hg, r0;
    afc_data = 14'h0ABC; afc_msb_lsb = 1'b0; afc_req = 1'b1;
    host_word = 18'h2AAA5; host_req = 1'b1;
    r0 = rise_cnt;
    @(posedge HCLK); #1;
    checks++; if (afc_grant !== 1'b1) begin errors++; $display("FAIL arb_afc_grant: got %b want 1", afc_grant); end
    checks++; if (host_grant !== 1'b0) begin errors++; $display("FAIL arb_host_lose: got %b want 0", host_grant); end
    afc_req = 1'b0;
    run_xfer(0, k, csl, ag, hg);
    checks++; if (k != 74) begin errors++; $display("FAIL arb_ready1: got %0d want 74", k); end
    checks++; if (hg != 0) begin errors++; $display("FAIL arb_host_early: got %0d want 0", hg); end
    checks++; if (cap !== 18'h0ABC3 || rise_cnt - r0 != 18) begin errors++; $display("FAIL arb_word1: got %h/%0d want 0abc3/18", cap, rise_cnt - r0); end
    r0 = rise_cnt;
    @(posedge HCLK); #1;
    checks++; if (host_grant !== 1'b1) begin errors++; $display("FAIL arb_host_grant: got %b want 1", host_grant); end
    checks++; if (max2831_ready !== 1'b0) begin errors++; $display("FAIL arb_host_ready: got %b want 0", max2831_ready); end
    host_req = 1'b0;
    run_xfer(0, k, csl, ag, hg);
    checks++; if (k != 74 || ag != 0) begin errors++; $display("FAIL arb_ready2: got %0d/%0d want 74/0", k, ag); end
    checks++; if (cap !== 18'h2AAA5 || rise_cnt - r0 != 18) begin errors++; $display("FAIL arb_word2: got %h/%0d want 2aaa5/18", cap, rise_cnt - r0); end
  endtask
`else
  task automatic test_host_disabled();
    int hg, csl, rdy_low;
    host_word = 18'h2AAA5; host_req = 1'b1;
    hg = 0; csl = 0; rdy_low = 0;
    repeat (200) begin
      @(posedge HCLK); #1;
      if (host_grant === 1'b1) hg++;
      if (spi_cs_n !== 1'b1) csl++;
      if (max2831_ready !== 1'b1) rdy_low++;
    end
    host_req = 1'b0;
    checks++; if (hg != 0) begin errors++; $display("FAIL dis_host_grant: got %0d want 0", hg); end
    checks++; if (csl != 0) begin errors++; $display("FAIL dis_cs_n: low %0d want 0", csl); end
    checks++; if (rdy_low != 0) begin errors++; $display("FAIL dis_ready: low %0d want 0", rdy_low); end
  endtask
`endif

  initial begin
    #1;
    test_reset();
    test_afc_r4();
    test_handshake();
    test_reset_mid();
`ifdef MAX2831_HOST_PORT_EN
    test_arbitration();
`else
    test_host_disabled();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/max2831_spi_writer.md
MAX2831_SPI_WRITER -- requirements
Module: max2831_spi_writer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, HCLK cycles per SCLK half-period; legal range 2..255.
REQ-002 SHALL have port HCLK  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port HRESET  input  1  synchronous, active-high reset.
REQ-004 SHALL have port afc_req  input  1  AFC write request (level), held until granted.
REQ-005 SHALL have port afc_data  input  14  AFC register payload D13:D0.
REQ-006 SHALL have port afc_msb_lsb  input  1  1 selects register R4 (addr 4'h4); 0 selects R3 (addr 4'h3).
REQ-007 SHALL have port afc_grant  output  1  one-cycle pulse: AFC request accepted.
REQ-008 SHALL have port host_req  input  1  host write request (level), held until granted.
REQ-009 SHALL have port host_word  input  18  complete host word {D13:D0, A3:A0}.
REQ-010 SHALL have port host_grant  output  1  one-cycle pulse: host request accepted.
REQ-011 SHALL have port max2831_ready  output  1  high only when the serializer is idle and can accept.
REQ-012 SHALL have port spi_cs_n  output  1  MAX2831 chip select, active low.
REQ-013 SHALL have port spi_sclk  output  1  serial clock, idle low.
REQ-014 SHALL have port spi_din  output  1  serial data, MSB first.

Function
REQ-015 SHALL implement states IDLE, SHIFT, GUARD; all outputs registered.
REQ-016 In IDLE with any request at edge T, SHALL latch the 18-bit word and enter SHIFT at T+1.
REQ-017 AFC word SHALL be {afc_data, 4'h4} if afc_msb_lsb=1, else {afc_data, 4'h3}; sampled in the accept cycle.
REQ-018 Arbitration SHALL be fixed priority: afc_req over host_req; the loser stays pending and is not granted.
REQ-019 The winner's grant SHALL be high for exactly cycle T+1 only, coincident with max2831_ready=0.
REQ-020 max2831_ready SHALL be 0 from T+1 through T+37*CLK_DIV and 1 again at T+1+37*CLK_DIV.
REQ-021 No request SHALL be accepted while max2831_ready=0; a request still high at the grant cycle is not re-accepted.
REQ-022 In SHIFT: spi_cs_n=0; each bit is a low phase of CLK_DIV cycles, then a high phase of CLK_DIV cycles; spi_din changes only at low-phase start.
REQ-023 SHALL shift 18 bits (bit17 first) using a 5-bit bit counter and an 8-bit divider counter; after bit0's high phase, spi_cs_n=1, spi_sclk=0, spi_din=0.
REQ-024 GUARD SHALL hold spi_cs_n=1 for CLK_DIV cycles (MAX2831 load/CS-high time), then return to IDLE.
REQ-025 Requests dropped before being granted SHALL be ignored without side effects.

Reset
REQ-026 While HRESET=1 at an edge: state=IDLE, spi_cs_n=1, spi_sclk=0, spi_din=0, afc_grant=0, host_grant=0, max2831_ready=1, counters=0.
REQ-027 Reset mid-transfer SHALL abort it; no partial word is completed; the first accept is possible on the first edge with HRESET=0.

Configuration
REQ-028 Macro MAX2831_HOST_PORT_EN defined: host port and arbitration present as specified.
REQ-029 Macro MAX2831_HOST_PORT_EN undefined: host_req and host_word ignored, host_grant tied 0, and only AFC requests are served; ports still exist.

Verification (CLK_DIV=2, macro defined unless stated)
REQ-030 afc_req=1, afc_msb_lsb=1, afc_data=14'h1000 -> afc_grant pulse at T+1, 18 SCLK rises shifting 18'h10004, cs_n low 72 cycles, ready high at T+75.
REQ-031 afc_msb_lsb=0, afc_data=14'h3078 -> serial word 18'h30783, data stable at each SCLK rising edge.
REQ-032 afc_req and host_req (host_word=18'h2AAA5) rise same cycle -> AFC word first; host_grant at the first accept after ready returns; 18'h2AAA5 shifted second.
REQ-033 AFC-style handshake with afc_req deasserted the cycle after grant&~ready -> exactly one transfer, no second grant.
REQ-034 HRESET=1 for one cycle during bit 9 -> next cycle cs_n=1, sclk=0, ready=1; new request fully serialized afterwards.
REQ-035 Macro undefined, host_req=1 held 200 cycles -> host_grant never asserted, spi_cs_n stays 1.
